// File: rtl/apb_arb_master.sv
// ---------------------------------------------------------------------------
// apb_arb_master
//
// APB master that shares one APB slave port between NREQ local requesters.
// A round-robin arbiter picks one request while the master is idle. The
// request is then run through the APB SETUP and ACCESS phases, and the result
// is returned to the requester that issued it.
//
// Handshakes:
//   req_valid[i] is held by requester i until req_ready[i] pulses.
//   req_ready is one-hot, combinational, and can only be high in IDLE.
//   The transfer is accepted on the clock edge that ends the req_ready cycle.
//   rsp_valid pulses for one cycle after the transfer completes or times out.
//   rsp_id, rsp_rdata and rsp_err keep their values until the next completion.
//
// Ports:
//   pclk, preset_n          clock and asynchronous active-low reset
//   req_valid/ready/write   per-requester handshake and direction
//   req_addr, req_wdata     flattened per-requester address and write data;
//                           requester i is at [i*W +: W]
//   rsp_valid/id/rdata/err  completion report
//   psel, penable, pwrite,
//   paddr, pwdata           APB request outputs
//   prdata, pready, pslverr APB response inputs
//   dbg_state               current FSM state, for observation only
// ---------------------------------------------------------------------------
module apb_arb_master #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    input  logic                     pslverr,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // The counter holds the number of ACCESS cycles already spent waiting.
    // It only has to count up to TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic              done;
    logic              timed_out;

    assign dbg_state = state_q;

    // Round-robin search. It starts one position after the last winner and
    // wraps modulo NREQ, so the last winner has the lowest priority.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The APB control outputs are decoded from the state. Because the state
    // register resets asynchronously, psel and penable drop as soon as reset
    // is asserted.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        psel      = 1'b0;
        penable   = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    state_d             = S_SETUP;
                end
            end
            S_SETUP: begin
                psel    = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rr_ptr    <= ID_W'(NREQ - 1);
            id_q      <= '0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done | timed_out;

            if (state_q == S_IDLE && grant_found) begin
                paddr  <= req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
                pwdata <= req_wdata[int'(grant_id)*DATA_W +: DATA_W];
                pwrite <= req_write[grant_id];
                id_q   <= grant_id;
                rr_ptr <= grant_id;
            end

            if (state_q == S_ACCESS && !(done || timed_out) && TIMEOUT != 0) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (done) begin
                rsp_id    <= id_q;
                rsp_err   <= pslverr;
                rsp_rdata <= pwrite ? '0 : prdata;
            end else if (timed_out) begin
                rsp_id    <= id_q;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_arb_master
//
// Directed test of apb_arb_master with NREQ=2 and TIMEOUT=16.
//
// The APB slave is a small memory model. Addresses of 32 and above return
// pslverr. The slave_hold flag keeps pready low. The driver pushes each
// expected response {id, err, rdata} onto exp_q, and the monitor pops and
// compares that entry whenever rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_apb_arb_master;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                 pclk;
    logic                 preset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic                 rsp_valid;
    logic [0:0]           rsp_id;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [AW-1:0]        paddr;
    logic [DW-1:0]        pwdata;
    logic [DW-1:0]        prdata;
    logic                 pready;
    logic                 pslverr;
    logic [1:0]           dbg_state;

    apb_arb_master #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic [DW-1:0] mem [0:31];
    logic          slave_hold;

    assign pready  = !slave_hold;
    assign pslverr = psel && penable && (paddr >= 32);
    assign prdata  = (paddr < 32) ? mem[paddr[4:0]] : '0;

    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite && !pslverr)
            mem[paddr[4:0]] <= pwdata;
    end

    // ---------------- scoreboard ----------------
    int tests  = 0;
    int failed = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        failed++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor process
    bit prev_done = 1'b0;
    always @(negedge pclk) begin
        logic [33:0] e;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_rsp");
            end else begin
                e = exp_q.pop_front();
                check("rsp", {rsp_id, rsp_err, rsp_rdata}, e);
            end
        end
        // A transfer completed on the previous edge, so psel must be low now.
        if (prev_done) check("psel_gap", psel, 1'b0);
        prev_done = psel && penable && pready;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_grant(output bit ok);
        int n;
        n = 0;
        @(negedge pclk);
        while (req_ready == '0 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        ok = (req_ready != '0);
        if (!ok) fail_now("grant_wait");
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge pclk);
            n++;
        end
        if (!rsp_valid) fail_now("rsp_wait");
    endtask

    task automatic issue(input int id, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit push,
                         input logic [33:0] exp, output int gcyc);
        bit ok;
        logic [1:0] oh;
        @(posedge pclk);
        #1;
        req_write[id]            = wr;
        req_addr[id*AW +: AW]    = addr;
        req_wdata[id*DW +: DW]   = wdata;
        req_valid[id]            = 1'b1;
        wait_grant(ok);
        gcyc = cyc;
        if (ok) begin
            oh = 2'b01 << id;
            check("grant_onehot", req_ready, oh);
            if (push) exp_q.push_back(exp);
        end
        @(posedge pclk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge pclk);
        #1;
        preset_n = 1'b0;
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  g, last, n, id, k;
        bit  ok;
        logic [1:0] oh;

        preset_n   = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        slave_hold = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;

        // Reset state
        @(negedge pclk);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_state", dbg_state, 2'd0);
        @(posedge pclk);
        #1;
        preset_n = 1'b1;

        // T1: req0 write addr 5, zero-wait slave, cycle-exact phases
        issue(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1, {1'b0, 1'b0, 32'h0}, g);
        @(negedge pclk);
        check("t1_setup_psel", psel, 1'b1);
        check("t1_setup_penable", penable, 1'b0);
        check("t1_setup_cycle", cyc - g, 1);
        check("t1_paddr", paddr, 32'd5);
        check("t1_pwrite", pwrite, 1'b1);
        check("t1_no_ready_busy", req_ready, 2'b00);
        @(negedge pclk);
        check("t1_access_penable", penable, 1'b1);
        check("t1_pwdata", pwdata, 32'hDEADBEEF);
        @(negedge pclk);
        check("t1_rsp_cycle", rsp_valid, 1'b1);

        // T2: req1 reads back the same address
        issue(1, 1'b0, 32'd5, 32'h0, 1'b1, {1'b1, 1'b0, 32'hDEADBEEF}, g);
        wait_rsp();

        // T3: both requesters valid right after reset; expect alternation,
        // with 3 cycles between grants. req0 writes addr k and req1 reads it back.
        pulse_reset();
        req_write = 2'b01;
        req_addr  = '0;
        req_wdata = {32'h0, 32'hA0};
        req_valid = 2'b11;
        last = 0;
        for (int t = 0; t < 8; t++) begin
            wait_grant(ok);
            if (!ok) break;
            id = t % 2;
            k  = t / 2;
            oh = 2'b01 << id;
            check("rr_grant", req_ready, oh);
            if (t > 0) check("xfer_period", cyc - last, 3);
            last = cyc;
            if (id == 0) exp_q.push_back({1'b0, 1'b0, 32'h0});
            else         exp_q.push_back({1'b1, 1'b0, 32'hA0 + k});
            @(posedge pclk);
            #1;
            if (k + 1 < 4) begin
                req_addr[id*AW +: AW]  = k + 1;
                req_wdata[id*DW +: DW] = 32'hA0 + k + 1;
            end else begin
                req_valid[id] = 1'b0;
            end
        end
        req_valid = '0;
        @(negedge pclk);
        wait_rsp();

        // T4: slave error on an out-of-range read
        issue(0, 1'b0, 32'd40, 32'h0, 1'b1, {1'b0, 1'b1, 32'h0}, g);
        wait_rsp();

        // T5: pready held low, so the transfer times out after 16 ACCESS cycles
        slave_hold = 1'b1;
        issue(1, 1'b0, 32'd2, 32'h0, 1'b1, {1'b1, 1'b1, 32'h0}, g);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge pclk);
            if (penable) n++;
            if (!psel && c > 0) break;
        end
        check("timeout_len", n, 16);
        check("timeout_rsp_valid", rsp_valid, 1'b1);
        slave_hold = 1'b0;

        // T6: reset asserted mid-ACCESS
        slave_hold = 1'b1;
        issue(0, 1'b0, 32'd3, 32'h0, 1'b0, '0, g);
        @(negedge pclk);
        @(negedge pclk);
        check("t6_in_access", penable, 1'b1);
        #2;
        preset_n = 1'b0;
        #1;
        check("t6_async_psel", psel, 1'b0);
        check("t6_async_penable", penable, 1'b0);
        check("t6_async_paddr", paddr, 32'h0);
        check("t6_async_rsp_valid", rsp_valid, 1'b0);
        slave_hold = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        req_write = 2'b00;
        req_addr  = {32'd9, 32'd7};
        req_valid = 2'b11;
        wait_grant(ok);
        if (ok) begin
            check("t6_first_grant", req_ready, 2'b01);
            exp_q.push_back({1'b0, 1'b0, 32'h1007});
        end
        @(posedge pclk);
        #1;
        req_valid = '0;
        @(negedge pclk);
        wait_rsp();

        repeat (4) @(negedge pclk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- APB master with round-robin arbitration. It shares one APB slave port (the apb_ram memory) between NREQ local requesters.
- It accepts one request at a time and sequences it through the APB phases IDLE -> SETUP -> ACCESS.
- It returns read data and error status to the requester that issued the request.
- It sits between bus-master agents and the APB slave, on the same pclk domain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles to wait for pready; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request; held until accepted.
- req_ready  out  NREQ  one-hot accept pulse, combinational.
- req_write  in  NREQ  per-requester 1=write, 0=read.
- req_addr  in  NREQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  flattened write data, same packing.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  $clog2(NREQ) (min 1)  index of the completing requester.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  slave error or timeout.
- psel, penable, pwrite  out  1 each  APB controls.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock, pclk. Reset preset_n is asynchronous and active-low.
- Reset values: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata, rsp_id = 0; rr_ptr=NREQ-1, so requester 0 wins first; wait counter=0.
- FSM IDLE: psel=0, penable=0.
  - If any req_valid is high, the winner is the first set bit searching upward from rr_ptr+1 modulo NREQ.
  - req_ready[winner]=1 this cycle only; it is combinational from state and req_valid.
  - On the clock edge: latch addr, write and wdata into paddr, pwrite, pwdata; latch the id; rr_ptr=winner; next state SETUP.
  - With no request, stay in IDLE.
- FSM SETUP: psel=1, penable=0, for exactly 1 cycle; next state ACCESS.
- FSM ACCESS: psel=1, penable=1. paddr, pwrite and pwdata stay stable throughout.
  - The wait counter increments each ACCESS cycle.
  - pready=1 sampled at the edge: complete. Capture rsp_err=pslverr. Capture rsp_rdata=prdata for reads, 0 for writes. Next state IDLE.
  - TIMEOUT!=0 and the counter reaches TIMEOUT with pready still 0: abort with rsp_err=1, rsp_rdata=0; next state IDLE.
- Completion: rsp_valid=1 for the single cycle after completion. This is the IDLE cycle, in which a new grant may be issued. rsp_id, rsp_rdata and rsp_err hold until the next completion.
- Latency and throughput:
  - Grant in cycle N; psel rises N+1; penable rises N+2.
  - A zero-wait slave gives rsp_valid at N+3.
  - Back-to-back transfers take 3 cycles each. psel is always deasserted for at least 1 cycle between transfers.
- One outstanding transfer only. req_ready is never asserted outside IDLE.
- Round-robin fairness: with all requesters valid continuously, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transfers.
- pwdata for reads: drive the latched req_wdata value; the slave ignores it.
- Address range is not checked here; out-of-range errors come from pslverr.
- Reset mid-transfer: all outputs return to reset values immediately and asynchronously. The in-flight transfer is dropped and no rsp_valid is generated. The wait counter clears.

Test Plan:
- Req0 write addr=5, wdata=0xDEADBEEF, zero-wait slave -> req_ready[0] in cycle N; psel rises N+1, penable N+2, paddr=5, pwrite=1; rsp_valid N+3 with rsp_id=0, rsp_err=0, rsp_rdata=0.
- Req1 read addr=5 after the previous write -> rsp_valid with rsp_id=1, rsp_rdata=0xDEADBEEF, rsp_err=0; psel low for at least 1 cycle between the two transfers.
- Req0 and req1 both valid from reset, 4 transfers each, addrs 0..3 -> grant order 0,1,0,1,...; each transfer takes exactly 3 cycles.
- Req0 read addr=40, slave returns pslverr=1 with pready=1 -> rsp_err=1, rsp_id=0.
- pready held 0, TIMEOUT=16 -> penable high for exactly 16 cycles; then psel drops, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- preset_n asserted during ACCESS -> psel and penable fall without waiting for a clock edge; no rsp_valid; after release, the first grant goes to req0.
